// File: rtl/pixel_buffer_if.sv
// Paint/clear/read bus for pixel_buffer.
// Master drives requests and read addresses; slave returns data and busy.
interface pixel_buffer_if #(
  parameter int CW = 3,
  parameter int AW = 8
);
  logic          brush;
  logic          ready;
  logic          bigBrush;
  logic [AW-1:0] wx;
  logic [AW-1:0] wy;
  logic [CW-1:0] newColor;
  logic          clear;
  logic [CW-1:0] clearColor;
  logic [AW-1:0] rx;
  logic [AW-1:0] ry;
  logic [CW-1:0] colorCode;
  logic          busy;

  modport master (
    output brush, ready, bigBrush,
    output wx, wy, newColor,
    output clear, clearColor,
    output rx, ry,
    input  colorCode, busy
  );

  modport slave (
    input  brush, ready, bigBrush,
    input  wx, wy, newColor,
    input  clear, clearColor,
    input  rx, ry,
    output colorCode, busy
  );
endinterface

// File: rtl/pixel_buffer.sv
// ROWS x COLS colour buffer with 1x1/2x2 brush,
// raster clear and a registered read port.
module pixel_buffer #(
  parameter int COLS = 8,
  parameter int ROWS = 8,
  parameter int CW   = 3,
  parameter int AW   = 8
) (
  input logic           clk,
  input logic           reset,
  pixel_buffer_if.slave bus
);
  localparam int CB = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RB = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [AW:0] CLIM = (AW+1)'(COLS);
  localparam logic [AW:0] RLIM = (AW+1)'(ROWS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PAINT = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] mem [ROWS][COLS];

  logic [AW-1:0] px, py;
  logic [CW-1:0] pc, cc;
  logic [1:0]    step;
  logic [CB-1:0] ccol;
  logic [RB-1:0] crow;

  logic          idle;
  logic          acc_clr;
  logic          acc_pnt;
  logic          rd_ok;
  logic          last;
  logic          we;
  logic          hit;
  logic [AW:0]   wc, wr;
  logic [CW-1:0] wd;

  assign idle    = (state == IDLE);
  assign acc_clr = idle & bus.clear;
  assign acc_pnt = idle & ~bus.clear
                 & bus.brush & bus.ready;
  assign bus.busy = ~idle;

  assign rd_ok = ({1'b0, bus.rx} < CLIM)
              && ({1'b0, bus.ry} < RLIM);

  assign last = (crow == RB'(ROWS-1))
             && (ccol == CB'(COLS-1));

  // step[0] selects the +1 column, step[1] the +1 row
  always_comb begin
    we = 1'b0;
    wc = {1'b0, bus.wx};
    wr = {1'b0, bus.wy};
    wd = bus.newColor;
    unique case (1'b1)
      acc_clr: begin
        we = 1'b1;
        wc = '0;
        wr = '0;
        wd = bus.clearColor;
      end
      acc_pnt: we = 1'b1;
      state == PAINT: begin
        we = 1'b1;
        wc = {1'b0, px} + (AW+1)'(step[0]);
        wr = {1'b0, py} + (AW+1)'(step[1]);
        wd = pc;
      end
      state == CLEAR: begin
        we = 1'b1;
        wc = (AW+1)'(ccol);
        wr = (AW+1)'(crow);
        wd = cc;
      end
      default: ;
    endcase
  end

  assign hit = we && (wc < CLIM) && (wr < RLIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.colorCode <= '0;
      px            <= '0;
      py            <= '0;
      pc            <= '0;
      cc            <= '0;
      step          <= '0;
      ccol          <= '0;
      crow          <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mem[r][c] <= '0;
    end else begin
      bus.colorCode <= rd_ok
        ? mem[bus.ry[RB-1:0]][bus.rx[CB-1:0]]
        : '0;
      if (hit)
        mem[wr[RB-1:0]][wc[CB-1:0]] <= wd;
      unique case (1'b1)
        acc_clr: begin
          state <= CLEAR;
          cc    <= bus.clearColor;
          ccol  <= CB'(1);
          crow  <= '0;
        end
        acc_pnt: begin
          if (bus.bigBrush)
            state <= PAINT;
          px   <= bus.wx;
          py   <= bus.wy;
          pc   <= bus.newColor;
          step <= 2'd1;
        end
        state == PAINT: begin
          step <= step + 2'd1;
          if (step == 2'd3)
            state <= IDLE;
        end
        state == CLEAR: begin
          if (last)
            state <= IDLE;
          if (ccol == CB'(COLS-1)) begin
            ccol <= '0;
            crow <= crow + RB'(1);
          end else begin
            ccol <= ccol + CB'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_buffer.sv
// Directed bench for pixel_buffer with a read
// scoreboard and a reference cell model.
module tb_pixel_buffer;
  localparam int COLS = 8;
  localparam int ROWS = 8;
  localparam int CW   = 3;
  localparam int AW   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pixel_buffer_if #(.CW(CW), .AW(AW)) bus ();

  pixel_buffer #(
    .COLS(COLS), .ROWS(ROWS),
    .CW(CW), .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    string         tag;
    logic [CW-1:0] exp;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] model [ROWS][COLS];
  int            checks = 0;
  int            errors = 0;

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rd(string tag, int x, int y,
                    logic [CW-1:0] e);
    exp_t t;
    bus.rx = AW'(x);
    bus.ry = AW'(y);
    sb.push_back('{tag, e});
    cyc();
    t = sb.pop_front();
    check(t.tag, 32'(bus.colorCode), 32'(t.exp));
  endtask

  task automatic read_all(string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        rd(tag, c, r, model[r][c]);
  endtask

  task automatic fill(logic [CW-1:0] v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model[r][c] = v;
  endtask

  task automatic put(int x, int y, logic [CW-1:0] v);
    if (x < COLS && y < ROWS)
      model[y][x] = v;
  endtask

  task automatic paint(int x, int y,
                       logic [CW-1:0] v, logic big);
    bus.brush    = 1'b1;
    bus.ready    = 1'b1;
    bus.bigBrush = big;
    bus.wx       = AW'(x);
    bus.wy       = AW'(y);
    bus.newColor = v;
    cyc();
    bus.brush    = 1'b0;
    bus.wx       = AW'($urandom);
    bus.wy       = AW'($urandom);
    bus.newColor = CW'($urandom);
    put(x, y, v);
    if (big) begin
      put(x + 1, y, v);
      put(x, y + 1, v);
      put(x + 1, y + 1, v);
    end
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    exp_t t;

    reset          = 1'b1;
    bus.brush      = 1'b0;
    bus.ready      = 1'b0;
    bus.bigBrush   = 1'b0;
    bus.wx         = '0;
    bus.wy         = '0;
    bus.newColor   = '0;
    bus.clear      = 1'b0;
    bus.clearColor = '0;
    bus.rx         = '0;
    bus.ry         = '0;
    fill('0);
    repeat (2) cyc();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_color", 32'(bus.colorCode), 0);
    reset = 1'b0;

    rd("rd_reset_34", 3, 4, 0);
    check("idle_busy", 32'(bus.busy), 0);

    // 1x1 stamp never raises busy
    paint(2, 5, 3'd6, 1'b0);
    check("p1_busy", 32'(bus.busy), 0);
    rd("p1_read", 2, 5, model[5][2]);

    rd("oob_x", COLS, 0, 0);
    rd("oob_y", 0, 255, 0);

    bus.ready    = 1'b0;
    bus.brush    = 1'b1;
    bus.wx       = 8'd1;
    bus.wy       = 8'd1;
    bus.newColor = 3'd7;
    cyc();
    bus.brush = 1'b0;
    rd("no_ready", 1, 1, model[1][1]);

    // 2x2 stamp clipped at the right edge
    paint(COLS-1, 1, 3'd5, 1'b1);
    busy_len(n);
    check("p2_busy_len", n, 3);
    rd("p2_a", COLS-1, 1, model[1][COLS-1]);
    rd("p2_b", COLS-1, 2, model[2][COLS-1]);
    rd("p2_c", 0, 1, model[1][0]);
    rd("p2_d", 0, 2, model[2][0]);

    // clear with a simultaneous brush; brush dropped
    bus.clear      = 1'b1;
    bus.clearColor = 3'd3;
    bus.brush      = 1'b1;
    bus.ready      = 1'b1;
    bus.bigBrush   = 1'b0;
    bus.wx         = 8'd0;
    bus.wy         = 8'd0;
    bus.newColor   = 3'd1;
    cyc();
    bus.clear      = 1'b0;
    bus.brush      = 1'b0;
    bus.clearColor = 3'd6;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      if (n == 5) begin
        bus.brush    = 1'b1;
        bus.wx       = 8'd2;
        bus.wy       = 8'd5;
        bus.newColor = 3'd7;
        bus.clear    = 1'b1;
        bus.clearColor = 3'd1;
      end else begin
        bus.brush = 1'b0;
        bus.clear = 1'b0;
      end
      cyc();
    end
    bus.brush = 1'b0;
    bus.clear = 1'b0;
    check("clr_busy_len", n, ROWS*COLS-1);
    fill(3'd3);
    rd("clr_paint_dropped", 2, 5, 3'd3);
    read_all("clr_cells");

    paint(COLS-1, ROWS-1, 3'd2, 1'b1);
    busy_len(n);
    check("corner_busy_len", n, 3);
    rd("corner_a", COLS-1, ROWS-1, model[ROWS-1][COLS-1]);
    rd("corner_nowrap_x", 0, ROWS-1, model[ROWS-1][0]);
    rd("corner_nowrap_y", COLS-1, 0, model[0][COLS-1]);
    rd("corner_nowrap_xy", 0, 0, model[0][0]);

    // wx at max must not alias to column 0
    paint(255, 0, 3'd4, 1'b1);
    busy_len(n);
    check("alias_busy_len", n, 3);
    rd("alias_00", 0, 0, model[0][0]);
    rd("alias_01", 0, 1, model[1][0]);

    bus.brush    = 1'b1;
    bus.ready    = 1'b1;
    bus.bigBrush = 1'b0;
    bus.wx       = 8'd4;
    bus.wy       = 8'd4;
    bus.newColor = 3'd6;
    bus.rx       = 8'd4;
    bus.ry       = 8'd4;
    sb.push_back('{"rw_same", model[4][4]});
    cyc();
    bus.brush = 1'b0;
    t = sb.pop_front();
    check(t.tag, 32'(bus.colorCode), 32'(t.exp));
    model[4][4] = 3'd6;
    rd("rw_after", 4, 4, model[4][4]);

    // abort a clear with reset
    bus.clear      = 1'b1;
    bus.clearColor = 3'd1;
    cyc();
    bus.clear = 1'b0;
    repeat (10) cyc();
    check("pre_abort_busy", 32'(bus.busy), 1);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_color", 32'(bus.colorCode), 0);
    fill('0);
    @(negedge clk);
    reset = 1'b0;
    paint(1, 1, 3'd4, 1'b0);
    read_all("abort_cells");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
